// File: rtl/uart_xcvr_param.sv
// Parametrised full-duplex UART transceiver: configurable data width, parity,
// stop bits, and a first-word-fall-through receive FIFO that reports framing,
// parity and overrun errors.
module uart_xcvr_param #(
  parameter int CLK_DIV    = 104,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en_sig,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_pin,
  input  logic                 rx_pin,
  input  logic                 rx_rd,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int CNT_W = $clog2(STOP_BITS * CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // Parity bit value that makes a frame carrying payload d satisfy the configured parity.
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------- transmitter ----------------
  state_t               tx_st, tx_st_n;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_n;
  logic [BIT_W-1:0]     tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_par, tx_par_n, tx_pin_n, tx_done_n;

  // TX control state; tx_pin is registered so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st   <= S_IDLE;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_pin  <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx_st   <= tx_st_n;
      tx_cnt  <= tx_cnt_n;
      tx_bit  <= tx_bit_n;
      tx_pin  <= tx_pin_n;
      tx_done <= tx_done_n;
    end
  end

  // TX payload shift register and parity bit; only meaningful once a frame is accepted.
  always_ff @(posedge clk) begin
    tx_sh  <= tx_sh_n;
    tx_par <= tx_par_n;
  end

  // TX next state: each state runs one bit period, STOP runs STOP_BITS periods.
  always_comb begin
    tx_st_n   = tx_st;
    tx_cnt_n  = tx_cnt + 1'b1;
    tx_bit_n  = tx_bit;
    tx_sh_n   = tx_sh;
    tx_par_n  = tx_par;
    tx_pin_n  = tx_pin;
    tx_done_n = 1'b0;
    case (tx_st)
      S_IDLE: begin
        tx_cnt_n = '0;
        tx_pin_n = 1'b1;
        if (tx_en_sig) begin
          tx_st_n  = S_START;
          tx_sh_n  = tx_data;
          tx_par_n = par_bit(tx_data);
          tx_pin_n = 1'b0;
        end
      end
      S_START: if (tx_cnt == BIT_END) begin
        tx_st_n  = S_DATA;
        tx_cnt_n = '0;
        tx_bit_n = '0;
        tx_pin_n = tx_sh[0];
      end
      S_DATA: if (tx_cnt == BIT_END) begin
        tx_cnt_n = '0;
        if (tx_bit == LAST_BIT) begin
          if (PARITY != 0) begin
            tx_st_n  = S_PAR;
            tx_pin_n = tx_par;
          end else begin
            tx_st_n  = S_STOP;
            tx_pin_n = 1'b1;
          end
        end else begin
          tx_bit_n = tx_bit + 1'b1;
          tx_sh_n  = tx_sh >> 1;
          tx_pin_n = tx_sh[1];
        end
      end
      S_PAR: if (tx_cnt == BIT_END) begin
        tx_st_n  = S_STOP;
        tx_cnt_n = '0;
        tx_pin_n = 1'b1;
      end
      S_STOP: if (tx_cnt == STOP_END) begin
        tx_st_n   = S_IDLE;
        tx_cnt_n  = '0;
        tx_done_n = 1'b1;
      end
      default: tx_st_n = S_IDLE;
    endcase
  end

  assign tx_busy = (tx_st != S_IDLE);

  // ---------------- receiver ----------------
  logic rx_s1, rx_s2, rx_s3;
  logic rx_fall;

  // Two-flop synchroniser plus one history flop for start-edge detection; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
    end else begin
      rx_s1 <= rx_pin;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;

  state_t               rx_st, rx_st_n;
  logic [CNT_W-1:0]     rx_cnt, rx_cnt_n;
  logic [BIT_W-1:0]     rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_pbit, rx_pbit_n;
  logic                 res_vld, res_vld_n, res_stop, res_stop_n;

  // RX control state; res_vld marks the single frame-resolution cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st    <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      res_vld  <= 1'b0;
      res_stop <= 1'b1;
    end else begin
      rx_st    <= rx_st_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      res_vld  <= res_vld_n;
      res_stop <= res_stop_n;
    end
  end

  // RX payload and received parity bit; held stable through the resolution cycle.
  always_ff @(posedge clk) begin
    rx_sh   <= rx_sh_n;
    rx_pbit <= rx_pbit_n;
  end

  // RX next state: half-bit start check, then one sample per bit period at mid-bit.
  always_comb begin
    rx_st_n    = rx_st;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_pbit_n  = rx_pbit;
    res_vld_n  = 1'b0;
    res_stop_n = res_stop;
    case (rx_st)
      S_IDLE: begin
        rx_cnt_n = '0;
        if (rx_fall) rx_st_n = S_START;
      end
      S_START: if (rx_cnt == HALF_END) begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        rx_st_n  = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rx_s2, rx_sh[DATA_BITS-1:1]};
        rx_bit_n = rx_bit + 1'b1;
        if (rx_bit == LAST_BIT) rx_st_n = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: if (rx_cnt == BIT_END) begin
        rx_cnt_n  = '0;
        rx_pbit_n = rx_s2;
        rx_st_n   = S_STOP;
      end
      S_STOP: if (rx_cnt == BIT_END) begin
        rx_cnt_n   = '0;
        res_vld_n  = 1'b1;
        res_stop_n = rx_s2;
        rx_st_n    = S_IDLE;
      end
      default: rx_st_n = S_IDLE;
    endcase
  end

  // Frame resolution: framing beats parity beats overrun; a pop frees room for the push.
  logic par_ok, push_req, fifo_full, push, pop;
  assign par_ok        = (PARITY == 0) || (rx_pbit == par_bit(rx_sh));
  assign rx_frame_err  = res_vld & ~res_stop;
  assign rx_parity_err = res_vld & res_stop & ~par_ok;
  assign push_req      = res_vld & res_stop & par_ok;
  assign pop           = rx_rd & rx_valid;
  assign rx_overrun    = push_req & fifo_full & ~pop;
  assign push          = push_req & (~fifo_full | pop);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     occ;

  assign fifo_full = (occ == OCC_FULL);
  assign rx_valid  = (occ != '0);
  assign rx_data   = rx_valid ? mem[rd_ptr] : '0;

  // FIFO pointers wrap naturally; occupancy separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage; a push into a full FIFO reuses the slot vacated by the same-cycle pop.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_sh;
  end
endmodule

// File: tb/tb_uart_xcvr_param.sv
// Directed bench for uart_xcvr_param: an 8N1 instance (tx waveform, loopback)
// and an 8E1 instance (loopback, error pulses, glitch, FIFO overrun, reset).
module tb_uart_xcvr_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8N1 instance, rx looped from its own tx
  logic       tx_en_n = 1'b0;
  logic [7:0] tx_data_n = 8'h00;
  logic       tx_busy_n, tx_done_n, tx_pin_n;
  logic       rx_rd_n = 1'b0;
  logic       rx_valid_n, rx_parity_err_n, rx_frame_err_n, rx_overrun_n;
  logic [7:0] rx_data_n;

  // 8E1 instance, rx from bench driver or loopback
  logic       tx_en_e = 1'b0;
  logic [7:0] tx_data_e = 8'h00;
  logic       tx_busy_e, tx_done_e, tx_pin_e;
  logic       rx_rd_e = 1'b0;
  logic       rx_valid_e, rx_parity_err_e, rx_frame_err_e, rx_overrun_e;
  logic [7:0] rx_data_e;
  logic       loop = 1'b0;
  logic       rx_drv = 1'b1;
  logic       rx_line_e;
  assign rx_line_e = loop ? tx_pin_e : rx_drv;

  uart_xcvr_param #(.CLK_DIV(104), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .tx_en_sig(tx_en_n), .tx_data(tx_data_n),
    .tx_busy(tx_busy_n), .tx_done(tx_done_n), .tx_pin(tx_pin_n), .rx_pin(tx_pin_n),
    .rx_rd(rx_rd_n), .rx_valid(rx_valid_n), .rx_data(rx_data_n),
    .rx_parity_err(rx_parity_err_n), .rx_frame_err(rx_frame_err_n), .rx_overrun(rx_overrun_n));

  uart_xcvr_param #(.CLK_DIV(104), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
    .clk(clk), .rst_n(rst_n), .tx_en_sig(tx_en_e), .tx_data(tx_data_e),
    .tx_busy(tx_busy_e), .tx_done(tx_done_e), .tx_pin(tx_pin_e), .rx_pin(rx_line_e),
    .rx_rd(rx_rd_e), .rx_valid(rx_valid_e), .rx_data(rx_data_e),
    .rx_parity_err(rx_parity_err_e), .rx_frame_err(rx_frame_err_e), .rx_overrun(rx_overrun_e));

  int errs = 0;
  int checks = 0;
  int pe_cnt = 0, fe_cnt = 0, ov_cnt = 0, n_err_cnt = 0;
  int pe0, fe0, ov0;
  logic [9:0] frame_a5;
  logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  // Error pulses last a full cycle; sample them mid-cycle.
  always @(negedge clk) begin
    if (rx_parity_err_e) pe_cnt++;
    if (rx_frame_err_e)  fe_cnt++;
    if (rx_overrun_e)    ov_cnt++;
    if (rx_parity_err_n | rx_frame_err_n | rx_overrun_n) n_err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_e();
    rx_rd_e = 1'b1;
    tick();
    rx_rd_e = 1'b0;
  endtask

  task automatic wait_done_e(input string tag);
    int n = 0;
    while (!tx_done_e && n < 1300) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, tx_done_e}, 32'd1);
  endtask

  // Drive one 8E1 frame bit by bit; rx_rd_e is raised only on tick rd_tick.
  task automatic send_rx(input logic [7:0] d, input logic pbit, input logic sbit, input int rd_tick);
    logic [10:0] fr;
    fr = {sbit, pbit, d, 1'b0};
    for (int t = 0; t < 11 * 104; t++) begin
      rx_drv  = fr[t / 104];
      rx_rd_e = (t == rd_tick);
      tick();
    end
    rx_drv  = 1'b1;
    rx_rd_e = 1'b0;
    repeat (120) tick();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    repeat (3) tick();
    check_eq("rst_tx_pin_n", {31'd0, tx_pin_n}, 32'd1);
    check_eq("rst_tx_busy_n", {31'd0, tx_busy_n}, 32'd0);
    check_eq("rst_tx_done_n", {31'd0, tx_done_n}, 32'd0);
    check_eq("rst_tx_pin_e", {31'd0, tx_pin_e}, 32'd1);
    check_eq("rst_rx_valid_e", {31'd0, rx_valid_e}, 32'd0);
    check_eq("rst_rx_data_e", {24'd0, rx_data_e}, 32'd0);
    check_eq("rst_errs_e", {29'd0, rx_parity_err_e, rx_frame_err_e, rx_overrun_e}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // ---- 8N1 tx 0xA5 waveform ----
    frame_a5  = {1'b1, 8'hA5, 1'b0};
    tx_data_n = 8'hA5;
    tx_en_n   = 1'b1;
    tick();
    tx_en_n   = 1'b0;
    for (int k = 1; k <= 1041; k++) begin
      if (k <= 1040 && (k % 104 == 1 || k % 104 == 0))
        check_eq($sformatf("a5_pin_c%0d", k), {31'd0, tx_pin_n}, {31'd0, frame_a5[(k - 1) / 104]});
      if (k == 1)    check_eq("a5_busy_c1", {31'd0, tx_busy_n}, 32'd1);
      if (k == 1040) check_eq("a5_done_c1040", {31'd0, tx_done_n}, 32'd0);
      if (k == 1041) begin
        check_eq("a5_done_c1041", {31'd0, tx_done_n}, 32'd1);
        check_eq("a5_busy_c1041", {31'd0, tx_busy_n}, 32'd0);
      end
      tick();
    end
    repeat (150) tick();
    check_eq("a5_loop_valid", {31'd0, rx_valid_n}, 32'd1);
    check_eq("a5_loop_data", {24'd0, rx_data_n}, 32'h0A5);

    // ---- 8E1 loopback, back-to-back 0x3C, 0xFF ----
    pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    loop = 1'b1;
    tx_data_e = 8'h3C;
    tx_en_e = 1'b1;
    tick();
    tx_en_e = 1'b0;
    wait_done_e("b2b_done1");
    check_eq("b2b_busy_at_done", {31'd0, tx_busy_e}, 32'd0);
    tx_data_e = 8'hFF;
    tx_en_e = 1'b1;
    tick();
    tx_en_e = 1'b0;
    check_eq("b2b_pin_start", {31'd0, tx_pin_e}, 32'd0);
    check_eq("b2b_busy2", {31'd0, tx_busy_e}, 32'd1);
    wait_done_e("b2b_done2");
    repeat (150) tick();
    check_eq("b2b_valid1", {31'd0, rx_valid_e}, 32'd1);
    check_eq("b2b_data1", {24'd0, rx_data_e}, 32'h3C);
    pop_e();
    check_eq("b2b_valid2", {31'd0, rx_valid_e}, 32'd1);
    check_eq("b2b_data2", {24'd0, rx_data_e}, 32'hFF);
    pop_e();
    check_eq("b2b_empty", {31'd0, rx_valid_e}, 32'd0);
    check_eq("b2b_no_errs", pe_cnt + fe_cnt + ov_cnt - pe0 - fe0 - ov0, 32'd0);
    loop = 1'b0;

    // ---- parity error, then framing error ----
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_rx(8'h01, 1'b0, 1'b1, -1);
    check_eq("perr_pulse", pe_cnt - pe0, 32'd1);
    check_eq("perr_valid", {31'd0, rx_valid_e}, 32'd0);
    send_rx(8'h01, 1'b1, 1'b0, -1);
    check_eq("ferr_pulse", fe_cnt - fe0, 32'd1);
    check_eq("ferr_no_perr", pe_cnt - pe0, 32'd1);
    check_eq("ferr_valid", {31'd0, rx_valid_e}, 32'd0);

    // ---- start-bit glitch ----
    pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    rx_drv = 1'b0;
    repeat (20) tick();
    rx_drv = 1'b1;
    repeat (200) tick();
    check_eq("glitch_valid", {31'd0, rx_valid_e}, 32'd0);
    check_eq("glitch_no_errs", pe_cnt + fe_cnt + ov_cnt - pe0 - fe0 - ov0, 32'd0);
    send_rx(8'h5A, 1'b0, 1'b1, -1);
    check_eq("glitch_next_valid", {31'd0, rx_valid_e}, 32'd1);
    check_eq("glitch_next_data", {24'd0, rx_data_e}, 32'h5A);
    pop_e();

    // ---- FIFO overrun ----
    ov0 = ov_cnt;
    for (int i = 0; i < 4; i++) send_rx(vals[i], 1'b0, 1'b1, -1);
    check_eq("ovr_none_yet", ov_cnt - ov0, 32'd0);
    send_rx(vals[4], 1'b0, 1'b1, -1);
    check_eq("ovr_pulse", ov_cnt - ov0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ovr_rd%0d", i), {24'd0, rx_data_e}, {24'd0, vals[i]});
      pop_e();
    end
    check_eq("ovr_empty", {31'd0, rx_valid_e}, 32'd0);

    // ---- full FIFO with simultaneous pop ----
    ov0 = ov_cnt;
    for (int i = 0; i < 4; i++) send_rx(vals[i], 1'b0, 1'b1, -1);
    send_rx(vals[4], 1'b0, 1'b1, 1095);
    check_eq("pp_no_overrun", ov_cnt - ov0, 32'd0);
    for (int i = 1; i < 5; i++) begin
      check_eq($sformatf("pp_rd%0d", i), {24'd0, rx_data_e}, {24'd0, vals[i]});
      pop_e();
    end
    check_eq("pp_empty", {31'd0, rx_valid_e}, 32'd0);

    // ---- reset mid-tx and mid-rx ----
    send_rx(8'h5A, 1'b0, 1'b1, -1);
    tx_data_e = 8'h96;
    tx_en_e = 1'b1;
    tick();
    tx_en_e = 1'b0;
    rx_drv = 1'b0;
    repeat (400) tick();
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_tx_pin", {31'd0, tx_pin_e}, 32'd1);
    check_eq("mid_rst_busy", {31'd0, tx_busy_e}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, rx_valid_e}, 32'd0);
    check_eq("mid_rst_data", {24'd0, rx_data_e}, 32'd0);
    rx_drv = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    loop = 1'b1;
    tx_data_e = 8'hC3;
    tx_en_e = 1'b1;
    tick();
    tx_en_e = 1'b0;
    wait_done_e("post_rst_done");
    repeat (150) tick();
    check_eq("post_rst_valid", {31'd0, rx_valid_e}, 32'd1);
    check_eq("post_rst_data", {24'd0, rx_data_e}, 32'hC3);
    pop_e();
    check_eq("post_rst_empty", {31'd0, rx_valid_e}, 32'd0);
    check_eq("post_rst_no_errs", pe_cnt + fe_cnt + ov_cnt - pe0 - fe0 - ov0, 32'd0);
    check_eq("n_inst_no_errs", n_err_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
